// File: rtl/ten_gig_drp_arbiter_pkg.sv
// Shared definitions for the 10G PCS/PMA DRP arbiter: arbiter state encoding,
// DRP bus widths, timeout counter width and the read-data code returned on a
// user-access timeout.
package ten_gig_drp_arbiter_pkg;

    localparam int DRP_ADDR_W    = 16;
    localparam int DRP_DATA_W    = 16;
    localparam int TIMEOUT_CNT_W = 10;

    // Returned on o_usr_do when a user access is abandoned for lack of drdy.
    localparam logic [15:0] DRP_TIMEOUT_CODE = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CORE      = 2'd1,
        ST_USR_ISSUE = 2'd2,
        ST_USR_WAIT  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/drp_timeout_counter.sv
// Cycle counter that watches a user DRP access waiting for drdy. Cleared while
// the arbiter is not waiting, counts every waiting cycle, and flags expiry on
// the P_LIMIT-th consecutive waiting cycle.
module drp_timeout_counter
    import ten_gig_drp_arbiter_pkg::*;
#(
    parameter int P_CNT_W = TIMEOUT_CNT_W,
    parameter int P_LIMIT = 1023
) (
    input  logic i_sys_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [P_CNT_W-1:0] LAST = P_CNT_W'(P_LIMIT - 1);

    logic [P_CNT_W-1:0] cnt_q;
    logic [P_CNT_W-1:0] cnt_d;

    // Next count: restart from zero whenever not waiting, otherwise advance.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + P_CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expire = i_en && !i_clear && (cnt_q == LAST);

endmodule

// File: rtl/ten_gig_drp_arbiter.sv
// Shares the GT DRP port between the PCS core DRP engine (req/gnt, core has
// priority, never pre-empted) and a single-shot user/management port whose
// access is held in a one-deep pending slot until the bus is free.
// Optional feature: define DRP_ARB_USR_TIMEOUT_EN to abandon a user access
// after P_TIMEOUT cycles without drdy (drdy+err pulse, data 16'hDEAD).
module ten_gig_drp_arbiter
    import ten_gig_drp_arbiter_pkg::*;
#(
    parameter int P_ADDR_W  = DRP_ADDR_W,
    parameter int P_DATA_W  = DRP_DATA_W,
    parameter int P_TIMEOUT = 1023
) (
    input  logic                i_sys_clk,
    input  logic                i_rst,
    input  logic                i_core_req,
    output logic                o_core_gnt,
    input  logic                i_core_den,
    input  logic                i_core_dwe,
    input  logic [P_ADDR_W-1:0] i_core_daddr,
    input  logic [P_DATA_W-1:0] i_core_di,
    output logic                o_core_drdy,
    output logic [P_DATA_W-1:0] o_core_do,
    input  logic                i_usr_den,
    input  logic                i_usr_dwe,
    input  logic [P_ADDR_W-1:0] i_usr_daddr,
    input  logic [P_DATA_W-1:0] i_usr_di,
    output logic                o_usr_busy,
    output logic                o_usr_drdy,
    output logic [P_DATA_W-1:0] o_usr_do,
    output logic                o_usr_err,
    output logic                o_gt_den,
    output logic                o_gt_dwe,
    output logic [P_ADDR_W-1:0] o_gt_daddr,
    output logic [P_DATA_W-1:0] o_gt_di,
    input  logic                i_gt_drdy,
    input  logic [P_DATA_W-1:0] i_gt_do
);

    arb_state_e          state_q;
    logic                core_gnt_q;
    logic                usr_busy_q;
    logic                usr_drdy_q;
    logic                usr_err_q;
    logic [P_DATA_W-1:0] usr_do_q;

    // Pending user access; the fields stay valid until the access completes
    // because no new strobe is accepted while busy.
    logic                pend_q;
    logic                pend_we_q;
    logic [P_ADDR_W-1:0] pend_addr_q;
    logic [P_DATA_W-1:0] pend_di_q;

    // Registered GT drive used for user accesses.
    logic                gt_den_q;
    logic                gt_dwe_q;
    logic [P_ADDR_W-1:0] gt_daddr_q;
    logic [P_DATA_W-1:0] gt_di_q;

    logic                timeout_w;

`ifdef DRP_ARB_USR_TIMEOUT_EN
    drp_timeout_counter #(
        .P_CNT_W (TIMEOUT_CNT_W),
        .P_LIMIT (P_TIMEOUT)
    ) u_timeout (
        .i_sys_clk (i_sys_clk),
        .i_rst     (i_rst),
        .i_clear   (state_q != ST_USR_WAIT),
        .i_en      (state_q == ST_USR_WAIT),
        .o_expire  (timeout_w)
    );
`else
    // Without the watchdog a user access waits for drdy indefinitely.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (P_TIMEOUT != 0);
    assign timeout_w          = 1'b0;
`endif

    // Arbiter FSM plus user-slot bookkeeping, all outputs registered.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            core_gnt_q  <= 1'b0;
            usr_busy_q  <= 1'b0;
            usr_drdy_q  <= 1'b0;
            usr_err_q   <= 1'b0;
            usr_do_q    <= '0;
            pend_q      <= 1'b0;
            pend_we_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_di_q   <= '0;
            gt_den_q    <= 1'b0;
            gt_dwe_q    <= 1'b0;
            gt_daddr_q  <= '0;
            gt_di_q     <= '0;
        end else begin
            usr_drdy_q <= 1'b0;
            usr_err_q  <= 1'b0;

            // User strobe intake: accept into the slot, or drop and flag.
            if (i_usr_den) begin
                if (usr_busy_q) begin
                    usr_err_q <= 1'b1;
                end else begin
                    pend_q      <= 1'b1;
                    pend_we_q   <= i_usr_dwe;
                    pend_addr_q <= i_usr_daddr;
                    pend_di_q   <= i_usr_di;
                    usr_busy_q  <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (i_core_req) begin
                        state_q    <= ST_CORE;
                        core_gnt_q <= 1'b1;
                    end else if (pend_q) begin
                        state_q    <= ST_USR_ISSUE;
                        pend_q     <= 1'b0;
                        gt_den_q   <= 1'b1;
                        gt_dwe_q   <= pend_we_q;
                        gt_daddr_q <= pend_addr_q;
                        gt_di_q    <= pend_di_q;
                    end
                end
                ST_CORE: begin
                    if (!i_core_req) begin
                        state_q    <= ST_IDLE;
                        core_gnt_q <= 1'b0;
                    end
                end
                ST_USR_ISSUE: begin
                    gt_den_q <= 1'b0;
                    gt_dwe_q <= 1'b0;
                    state_q  <= ST_USR_WAIT;
                end
                ST_USR_WAIT: begin
                    if (i_gt_drdy) begin
                        usr_drdy_q <= 1'b1;
                        usr_do_q   <= pend_we_q ? '0 : i_gt_do;
                        usr_busy_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (timeout_w) begin
                        usr_drdy_q <= 1'b1;
                        usr_err_q  <= 1'b1;
                        usr_do_q   <= P_DATA_W'(DRP_TIMEOUT_CODE);
                        usr_busy_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // While the core owns the bus its pins pass straight through to the GT.
    assign o_gt_den    = core_gnt_q ? i_core_den   : gt_den_q;
    assign o_gt_dwe    = core_gnt_q ? i_core_dwe   : gt_dwe_q;
    assign o_gt_daddr  = core_gnt_q ? i_core_daddr : gt_daddr_q;
    assign o_gt_di     = core_gnt_q ? i_core_di    : gt_di_q;

    assign o_core_gnt  = core_gnt_q;
    assign o_core_drdy = i_gt_drdy & core_gnt_q;
    assign o_core_do   = i_gt_do;

    assign o_usr_busy  = usr_busy_q;
    assign o_usr_drdy  = usr_drdy_q;
    assign o_usr_do    = usr_do_q;
    assign o_usr_err   = usr_err_q;

endmodule

// File: tb/tb_ten_gig_drp_arbiter.sv
// Bench for ten_gig_drp_arbiter: a GT DRP responder backed by a memory, a
// transaction-level expected-memory model, directed checks of latency and
// arbitration rules, then randomized core/user traffic. Works with and without
// DRP_ARB_USR_TIMEOUT_EN.
module tb_ten_gig_drp_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_core_req, i_core_den, i_core_dwe;
    logic [15:0] i_core_daddr, i_core_di;
    logic        o_core_gnt, o_core_drdy;
    logic [15:0] o_core_do;
    logic        i_usr_den, i_usr_dwe;
    logic [15:0] i_usr_daddr, i_usr_di;
    logic        o_usr_busy, o_usr_drdy, o_usr_err;
    logic [15:0] o_usr_do;
    logic        o_gt_den, o_gt_dwe;
    logic [15:0] o_gt_daddr, o_gt_di;
    logic        i_gt_drdy = 1'b0;
    logic [15:0] i_gt_do = 16'h0;

    int checks = 0;
    int errors = 0;

    ten_gig_drp_arbiter #(.P_ADDR_W(16), .P_DATA_W(16), .P_TIMEOUT(TO)) dut (
        .i_sys_clk(clk), .i_rst(rst),
        .i_core_req(i_core_req), .o_core_gnt(o_core_gnt),
        .i_core_den(i_core_den), .i_core_dwe(i_core_dwe),
        .i_core_daddr(i_core_daddr), .i_core_di(i_core_di),
        .o_core_drdy(o_core_drdy), .o_core_do(o_core_do),
        .i_usr_den(i_usr_den), .i_usr_dwe(i_usr_dwe),
        .i_usr_daddr(i_usr_daddr), .i_usr_di(i_usr_di),
        .o_usr_busy(o_usr_busy), .o_usr_drdy(o_usr_drdy),
        .o_usr_do(o_usr_do), .o_usr_err(o_usr_err),
        .o_gt_den(o_gt_den), .o_gt_dwe(o_gt_dwe),
        .o_gt_daddr(o_gt_daddr), .o_gt_di(o_gt_di),
        .i_gt_drdy(i_gt_drdy), .i_gt_do(i_gt_do)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Move to just after the next falling edge: stimulus and sampling point.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Expected memory (updated at transaction issue) and GT memory (updated
    // only by accesses that actually reach the GT pins).
    logic [15:0] model_mem [logic [15:0]];
    logic [15:0] gt_mem    [logic [15:0]];

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction

    function automatic logic [15:0] gt_rd(input logic [15:0] a);
        return gt_mem.exists(a) ? gt_mem[a] : init_val(a);
    endfunction

    // GT responder: sees den on the falling edge, answers resp_delay cycles later.
    bit          gt_mute    = 1'b0;
    bit          stray_drdy = 1'b0;
    int          resp_delay = 1;
    bit          outstanding = 1'b0;
    int          rcnt = 0;
    logic        op_we;
    logic [15:0] op_addr, op_di;

    always @(negedge clk) begin
        i_gt_drdy = stray_drdy;
        i_gt_do   = 16'($urandom);
        if (rst) begin
            outstanding = 1'b0;
        end else begin
            if (outstanding) begin
                rcnt--;
                if (rcnt == 0) begin
                    outstanding = 1'b0;
                    i_gt_drdy   = 1'b1;
                    if (op_we) gt_mem[op_addr] = op_di;
                    else       i_gt_do = gt_rd(op_addr);
                end
            end
            if (o_gt_den && !gt_mute) begin
                chk("gt_overlap", 32'(outstanding), 32'd0);
                outstanding = 1'b1;
                rcnt        = resp_delay;
                op_we       = o_gt_dwe;
                op_addr     = o_gt_daddr;
                op_di       = o_gt_di;
            end
        end
    end

    // One user access; latency from strobe to drdy is 2 + resp_delay + 1.
    task automatic usr_op(input logic we, input logic [15:0] a, input logic [15:0] d, input bit lat);
        logic [15:0] exp;
        int n;
        exp = we ? 16'h0 : model_rd(a);
        if (we) model_mem[a] = d;
        i_usr_den = 1'b1; i_usr_dwe = we; i_usr_daddr = a; i_usr_di = d;
        step();
        i_usr_den = 1'b0;
        n = 1;
        while (!o_usr_drdy && n < 200) begin step(); n++; end
        chk("usr_done", 32'(o_usr_drdy), 32'd1);
        chk("usr_do", 32'(o_usr_do), 32'(exp));
        chk("usr_err0", 32'(o_usr_err), 32'd0);
        chk("usr_busy_clr", 32'(o_usr_busy), 32'd0);
        if (lat) chk("usr_lat", 32'(n), 32'(resp_delay + 3));
        $display("usr %s addr=%h data=%h cycles=%0d", we ? "wr" : "rd", a, we ? d : o_usr_do, n);
    endtask

    // One core ownership session with nops accesses.
    task automatic core_session(input int nops);
        int n;
        logic we;
        logic [15:0] a, d, exp;
        i_core_req = 1'b1;
        n = 0;
        do begin step(); n++; end while (!o_core_gnt && n < 200);
        chk("cs_gnt", 32'(o_core_gnt), 32'd1);
        for (int k = 0; k < nops; k++) begin
            we  = 1'($urandom_range(0, 1));
            a   = {12'h800, 4'($urandom_range(0, 15))};
            d   = 16'($urandom);
            exp = we ? 16'h0 : model_rd(a);
            if (we) model_mem[a] = d;
            i_core_den = 1'b1; i_core_dwe = we; i_core_daddr = a; i_core_di = d;
            #1;
            chk("cs_gt_addr", 32'(o_gt_daddr), 32'(a));
            chk("cs_gt_dwe", 32'(o_gt_dwe), 32'(we));
            chk("cs_gt_di", 32'(o_gt_di), 32'(d));
            step();
            i_core_den = 1'b0;
            n = 1;
            while (!o_core_drdy && n < 100) begin step(); n++; end
            chk("cs_drdy", 32'(o_core_drdy), 32'd1);
            if (!we) chk("cs_do", 32'(o_core_do), 32'(exp));
            $display("core %s addr=%h data=%h", we ? "wr" : "rd", a, we ? d : o_core_do);
        end
        i_core_req = 1'b0;
        step();
        chk("cs_gnt_off", 32'(o_core_gnt), 32'd0);
    endtask

    task automatic usr_rand(input bit lat);
        usr_op(1'($urandom_range(0, 1)), {12'h000, 4'($urandom_range(0, 15))}, 16'($urandom), lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        rst = 1'b1;
        i_core_req = 0; i_core_den = 0; i_core_dwe = 0; i_core_daddr = 0; i_core_di = 0;
        i_usr_den = 0; i_usr_dwe = 0; i_usr_daddr = 0; i_usr_di = 0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_gnt", 32'(o_core_gnt), 32'd0);
        chk("rst_busy", 32'(o_usr_busy), 32'd0);
        chk("rst_udrdy", 32'(o_usr_drdy), 32'd0);
        chk("rst_uerr", 32'(o_usr_err), 32'd0);
        chk("rst_gden", 32'(o_gt_den), 32'd0);
        chk("rst_gdwe", 32'(o_gt_dwe), 32'd0);
        chk("rst_gaddr", 32'(o_gt_daddr), 32'd0);
        chk("rst_gdi", 32'(o_gt_di), 32'd0);
        chk("rst_udo", 32'(o_usr_do), 32'd0);

        // Core-only read.
        gt_mem[16'h0040] = 16'h1234; model_mem[16'h0040] = 16'h1234;
        resp_delay = 2;
        i_core_req = 1'b1;
        step();
        chk("core_gnt_rise", 32'(o_core_gnt), 32'd1);
        i_core_den = 1'b1; i_core_dwe = 1'b0; i_core_daddr = 16'h0040;
        #1;
        chk("core_gt_den", 32'(o_gt_den), 32'd1);
        chk("core_gt_addr", 32'(o_gt_daddr), 32'h0040);
        step();
        i_core_den = 1'b0;
        n = 1;
        while (!o_core_drdy && n < 50) begin step(); n++; end
        chk("core_drdy", 32'(o_core_drdy), 32'd1);
        chk("core_do", 32'(o_core_do), 32'h1234);
        i_core_req = 1'b0;
        step();
        chk("core_gnt_fall", 32'(o_core_gnt), 32'd0);
        $display("core rd addr=0040 data=%h", o_core_do);

        // User read from idle: den at +2, drdy 3 cycles after den.
        gt_mem[16'h0011] = 16'hBEEF; model_mem[16'h0011] = 16'hBEEF;
        resp_delay = 3;
        i_usr_den = 1'b1; i_usr_dwe = 1'b0; i_usr_daddr = 16'h0011; i_usr_di = 16'h0;
        step();
        i_usr_den = 1'b0;
        chk("ur_busy_set", 32'(o_usr_busy), 32'd1);
        chk("ur_den_early", 32'(o_gt_den), 32'd0);
        step();
        chk("ur_gt_den", 32'(o_gt_den), 32'd1);
        chk("ur_gt_addr", 32'(o_gt_daddr), 32'h0011);
        chk("ur_gt_dwe", 32'(o_gt_dwe), 32'd0);
        step();
        chk("ur_den_1cyc", 32'(o_gt_den), 32'd0);
        n = 3;
        while (!o_usr_drdy && n < 50) begin step(); n++; end
        chk("ur_lat", 32'(n), 32'd6);
        chk("ur_do", 32'(o_usr_do), 32'hBEEF);
        chk("ur_busy_clr", 32'(o_usr_busy), 32'd0);
        step();
        chk("ur_drdy_pulse", 32'(o_usr_drdy), 32'd0);
        $display("usr rd addr=0011 cycles=%0d", n);

        // Simultaneous core request and user strobe.
        gt_mem[16'h0022] = 16'h7E57; model_mem[16'h0022] = 16'h7E57;
        resp_delay = 2;
        i_core_req = 1'b1; i_core_den = 1'b0; i_core_daddr = 16'h8077;
        i_usr_den = 1'b1; i_usr_dwe = 1'b0; i_usr_daddr = 16'h0022;
        step();
        i_usr_den = 1'b0; i_usr_daddr = 16'h7FFF;
        chk("sim_gnt", 32'(o_core_gnt), 32'd1);
        chk("sim_busy", 32'(o_usr_busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("sim_hold", 32'(o_gt_den), 32'd0);
        end
        i_core_req = 1'b0;
        step();
        chk("sim_gnt_off", 32'(o_core_gnt), 32'd0);
        chk("sim_den_wait", 32'(o_gt_den), 32'd0);
        step();
        chk("sim_usr_den", 32'(o_gt_den), 32'd1);
        chk("sim_usr_addr", 32'(o_gt_daddr), 32'h0022);
        n = 0;
        while (!o_usr_drdy && n < 50) begin step(); n++; end
        chk("sim_do", 32'(o_usr_do), 32'h7E57);
        $display("usr rd addr=0022 after core release data=%h", o_usr_do);

        // Strobe while busy is dropped with an error pulse.
        resp_delay = 5;
        model_mem[16'h0033] = 16'hA5A5;
        i_usr_den = 1'b1; i_usr_dwe = 1'b1; i_usr_daddr = 16'h0033; i_usr_di = 16'hA5A5;
        step();
        i_usr_den = 1'b0;
        step();
        i_usr_den = 1'b1; i_usr_dwe = 1'b1; i_usr_daddr = 16'h0044; i_usr_di = 16'h1111;
        step();
        i_usr_den = 1'b0;
        chk("drop_err", 32'(o_usr_err), 32'd1);
        step();
        chk("drop_err_pulse", 32'(o_usr_err), 32'd0);
        n = 0;
        while (!o_usr_drdy && n < 50) begin step(); n++; end
        chk("drop_done", 32'(o_usr_drdy), 32'd1);
        chk("drop_wr_do", 32'(o_usr_do), 32'd0);
        chk("drop_mem", 32'(gt_rd(16'h0033)), 32'hA5A5);
        chk("drop_no_write", 32'(gt_mem.exists(16'h0044)), 32'd0);
        $display("usr wr addr=0033 with dropped strobe");
        step();
        usr_op(1'b0, 16'h0033, 16'h0, 1'b1);

        // drdy while idle must not reach either master.
        stray_drdy = 1'b1;
        step();
        stray_drdy = 1'b0;
        chk("stray_core", 32'(o_core_drdy), 32'd0);
        step();
        chk("stray_usr", 32'(o_usr_drdy), 32'd0);

        // Unanswered user access.
        gt_mute = 1'b1;
        i_usr_den = 1'b1; i_usr_dwe = 1'b0; i_usr_daddr = 16'h0055;
        step();
        i_usr_den = 1'b0;
        n = 1;
`ifdef DRP_ARB_USR_TIMEOUT_EN
        while (!o_usr_drdy && n < 100) begin step(); n++; end
        chk("to_lat", 32'(n), 32'(2 + TO + 1));
        chk("to_err", 32'(o_usr_err), 32'd1);
        chk("to_do", 32'(o_usr_do), 32'hDEAD);
        chk("to_busy", 32'(o_usr_busy), 32'd0);
        step();
        chk("to_err_pulse", 32'(o_usr_err), 32'd0);
        $display("usr rd addr=0055 timed out cycles=%0d", n);
        i_usr_den = 1'b1; i_usr_dwe = 1'b0; i_usr_daddr = 16'h0066;
        step();
        i_usr_den = 1'b0;
        repeat (5) step();
`else
        seen = 1'b0;
        repeat (30) begin step(); if (o_usr_drdy) seen = 1'b1; end
        chk("nto_no_drdy", 32'(seen), 32'd0);
        chk("nto_busy", 32'(o_usr_busy), 32'd1);
        $display("usr rd addr=0055 still waiting");
`endif

        // Asynchronous reset while waiting for drdy.
        #2 rst = 1'b1;
        #1;
        chk("arst_gnt", 32'(o_core_gnt), 32'd0);
        chk("arst_busy", 32'(o_usr_busy), 32'd0);
        chk("arst_udrdy", 32'(o_usr_drdy), 32'd0);
        chk("arst_uerr", 32'(o_usr_err), 32'd0);
        chk("arst_gt", 32'({o_gt_den, o_gt_dwe, o_gt_daddr, o_gt_di}), 32'd0);
        chk("arst_udo", 32'(o_usr_do), 32'd0);
        step();
        rst = 1'b0;
        gt_mute = 1'b0;
        seen = 1'b0;
        repeat (20) begin step(); if (o_usr_drdy) seen = 1'b1; end
        chk("arst_no_drdy", 32'(seen), 32'd0);
        chk("arst_idle_busy", 32'(o_usr_busy), 32'd0);

        // Randomized traffic against the memory model.
        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = $urandom_range(0, 2);
            resp_delay = $urandom_range(1, 4);
            case (kind)
                0: usr_rand(1'b1);
                1: core_session($urandom_range(1, 3));
                default: begin
                    fork
                        usr_rand(1'b0);
                        core_session($urandom_range(1, 3));
                    join
                end
            endcase
            repeat ($urandom_range(0, 2)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
